// File: rtl/prod_accum.sv
// prod_accum: accumulator stage behind the 5-bit signed multiplier.
//
// It takes 10-bit product words {sign, 9-bit two's-complement result}
// through a valid/ready handshake. It sums a programmed number of them
// into a signed ACC_W-bit accumulator. When the run ends it shows the
// final sum together with a one-cycle acc_valid pulse.
//
// Parameters:
//   ACC_W  accumulator width, signed (minimum 10)
//   LEN_W  width of the term-count field
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       begin a new run (sampled only in IDLE)
//   len         number of products in the run (sampled with start)
//   prod_in     product word: [9] operand-sign XOR, [8:0] signed result
//   prod_valid  prod_in is valid this cycle
//   prod_ready  block accepts prod_in this cycle
//   acc_out     accumulated signed sum
//   acc_valid   one-cycle pulse when acc_out is final for the run
//   busy        run in progress
//   sign_err    sticky per run: an accepted product had an inconsistent sign bit
//   ovf         sticky per run: the accumulator overflowed its signed range
//
// Optional feature:
//   PROD_ACCUM_SAT_EN  when defined, acc_out saturates on overflow.
//                      When undefined, acc_out wraps modulo 2^ACC_W.

module prod_accum #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [9:0]       prod_in,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             busy,
  output logic             sign_err,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [LEN_W-1:0] remaining;
  logic             transfer;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic [ACC_W-1:0] next_acc;
  logic             sign_bad;

  assign transfer = (state == ACCUM) && prod_valid;

  // The sign bit is redundant with bit 8 of the result, so only bits 8:0
  // are sign-extended. Bit 9 is used only for the consistency check.
  assign addend   = {{(ACC_W-9){prod_in[8]}}, prod_in[8:0]};
  assign sum      = acc_out + addend;
  assign add_ovf  = (addend[ACC_W-1] == acc_out[ACC_W-1]) &&
                    (sum[ACC_W-1] != acc_out[ACC_W-1]);
  assign sign_bad = (prod_in[8:0] != 9'd0) && (prod_in[9] != prod_in[8]);

  // Value that acc_out takes on a transfer. With saturation, the clamp
  // direction follows the sign of the old accumulator. An overflow only
  // happens when both operands share that sign.
`ifdef PROD_ACCUM_SAT_EN
  always_comb begin
    next_acc = sum;
    if (add_ovf) begin
      if (acc_out[ACC_W-1])
        next_acc = {1'b1, {(ACC_W-1){1'b0}}};
      else
        next_acc = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign next_acc = sum;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic and the handshake/status outputs decoded from state.
  // DONE always lasts exactly one cycle and then returns to IDLE.
  always_comb begin
    next_state = state;
    prod_ready = 1'b0;
    busy       = 1'b0;
    acc_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          next_state = (len != '0) ? ACCUM : DONE;
      end
      ACCUM: begin
        prod_ready = 1'b1;
        busy       = 1'b1;
        if (transfer && (remaining == LEN_W'(1)))
          next_state = DONE;
      end
      DONE: begin
        acc_valid  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath. Any accepted start clears the sum and the sticky flags, so a
  // len=0 run reports zero with clean status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out   <= '0;
      remaining <= '0;
      sign_err  <= 1'b0;
      ovf       <= 1'b0;
    end else if (state == IDLE && start) begin
      acc_out   <= '0;
      remaining <= len;
      sign_err  <= 1'b0;
      ovf       <= 1'b0;
    end else if (transfer) begin
      acc_out   <= next_acc;
      remaining <= remaining - LEN_W'(1);
      sign_err  <= sign_err | sign_bad;
      ovf       <= ovf | add_ovf;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed testbench for prod_accum.
//
// Two instances share the same stimulus. The default-width instance
// (ACC_W=16) is used for the functional scenarios. A narrow instance
// (ACC_W=10) is used to reach signed overflow.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_prod_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic [9:0] prod_in;
  logic       prod_valid;

  logic        prod_ready, acc_valid, busy, sign_err, ovf;
  logic [15:0] acc_out;
  logic        prod_ready10, acc_valid10, busy10, sign_err10, ovf10;
  logic [9:0]  acc_out10;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  prod_accum #(.ACC_W(16), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .acc_out(acc_out), .acc_valid(acc_valid), .busy(busy),
    .sign_err(sign_err), .ovf(ovf)
  );

  prod_accum #(.ACC_W(10), .LEN_W(4)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready10),
    .acc_out(acc_out10), .acc_valid(acc_valid10), .busy(busy10),
    .sign_err(sign_err10), .ovf(ovf10)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = '0; prod_in = '0; prod_valid = 1'b0;
    step(); step();
    tests_run++;
    if ({acc_out, acc_valid, busy, prod_ready, sign_err, ovf} !== 21'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got %h exp 0",
               {acc_out, acc_valid, busy, prod_ready, sign_err, ovf});
    end
    rst_n = 1'b1;
    step();
    tests_run++;
    if ({acc_valid, busy, prod_ready} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset got %b exp 000", {acc_valid, busy, prod_ready});
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; len = 4'd3;
    step();
    start = 1'b0;
    tests_run++;
    if ({busy, prod_ready} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL mid_run_busy got %b exp 11", {busy, prod_ready});
    end
    prod_valid = 1'b1; prod_in = 10'h3D8;
    step();
    prod_in = 10'h3DF;
    step();
    prod_valid = 1'b0;
    tests_run++;
    if (acc_out !== 16'hFFB7) begin
      tests_failed++;
      $display("[TB] FAIL mid_run_partial got %h exp ffb7", acc_out);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({acc_out, acc_valid, busy, prod_ready, sign_err, ovf} !== 21'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_run_reset got %h exp 0",
               {acc_out, acc_valid, busy, prod_ready, sign_err, ovf});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    start = 1'b1; len = 4'd3;
    step();
    start = 1'b0;
    prod_valid = 1'b1; prod_in = 10'h3D8;
    step();
    prod_in = 10'h3DF;
    step();
    prod_in = 10'h06E;
    step();
    prod_valid = 1'b0;
    tests_run++;
    if ({acc_valid, busy, prod_ready} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL nominal_done_flags got %b exp 100", {acc_valid, busy, prod_ready});
    end
    tests_run++;
    if (acc_out !== 16'd37) begin
      tests_failed++;
      $display("[TB] FAIL nominal_sum got %0d exp 37", $signed(acc_out));
    end
    tests_run++;
    if ({sign_err, ovf} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL nominal_status got %b exp 00", {sign_err, ovf});
    end
    step();
    tests_run++;
    if (acc_valid !== 1'b0 || acc_out !== 16'd37) begin
      tests_failed++;
      $display("[TB] FAIL nominal_pulse_width got valid=%b acc=%0d exp valid=0 acc=37",
               acc_valid, $signed(acc_out));
    end
  endtask

  task automatic test_stalls();
    prod_valid = 1'b1; prod_in = 10'd5;
    step();
    tests_run++;
    if (acc_out !== 16'd37) begin
      tests_failed++;
      $display("[TB] FAIL idle_valid_ignored got %0d exp 37", $signed(acc_out));
    end
    prod_valid = 1'b0; start = 1'b1; len = 4'd2;
    step();
    start = 1'b0; prod_valid = 1'b1; prod_in = 10'd5;
    step();
    prod_valid = 1'b0; start = 1'b1; len = 4'd5;
    step();
    start = 1'b0;
    tests_run++;
    if (acc_out !== 16'd5 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stall_hold got acc=%0d busy=%b exp acc=5 busy=1",
               $signed(acc_out), busy);
    end
    step();
    prod_valid = 1'b1; prod_in = 10'd7;
    step();
    tests_run++;
    if (acc_valid !== 1'b1 || acc_out !== 16'd12) begin
      tests_failed++;
      $display("[TB] FAIL stall_sum got valid=%b acc=%0d exp valid=1 acc=12",
               acc_valid, $signed(acc_out));
    end
    prod_in = 10'd100; start = 1'b1; len = 4'd3;
    step();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || acc_valid !== 1'b0 || acc_out !== 16'd12) begin
      tests_failed++;
      $display("[TB] FAIL done_ignores_inputs got busy=%b valid=%b acc=%0d exp 0 0 12",
               busy, acc_valid, $signed(acc_out));
    end
    prod_valid = 1'b0;
    step();
    tests_run++;
    if (busy !== 1'b0 || acc_out !== 16'd12) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_done got busy=%b acc=%0d exp 0 12", busy, $signed(acc_out));
    end
  endtask

  task automatic test_sign_err();
    start = 1'b1; len = 4'd2;
    step();
    start = 1'b0; prod_valid = 1'b1; prod_in = 10'h1F0;
    step();
    tests_run++;
    if (sign_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sign_err_set got %b exp 1", sign_err);
    end
    prod_in = 10'h005;
    step();
    prod_valid = 1'b0;
    tests_run++;
    if (acc_valid !== 1'b1 || acc_out !== 16'hFFF5 || sign_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sign_err_run got valid=%b acc=%h err=%b exp 1 fff5 1",
               acc_valid, acc_out, sign_err);
    end
    step();
    tests_run++;
    if (sign_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL sign_err_sticky got %b exp 1", sign_err);
    end
    start = 1'b1; len = 4'd1;
    step();
    start = 1'b0;
    tests_run++;
    if (sign_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sign_err_clear got %b exp 0", sign_err);
    end
    prod_valid = 1'b1; prod_in = 10'h200;
    step();
    prod_valid = 1'b0;
    tests_run++;
    if (acc_valid !== 1'b1 || acc_out !== 16'd0 || sign_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL neg_zero_legal got valid=%b acc=%h err=%b exp 1 0000 0",
               acc_valid, acc_out, sign_err);
    end
    step();
  endtask

  task automatic test_len_zero();
    start = 1'b1; len = 4'd1;
    step();
    start = 1'b0; prod_valid = 1'b1; prod_in = 10'd9;
    step();
    prod_valid = 1'b0;
    tests_run++;
    if (acc_out !== 16'd9) begin
      tests_failed++;
      $display("[TB] FAIL len_one_sum got %0d exp 9", $signed(acc_out));
    end
    step();
    start = 1'b1; len = 4'd0;
    step();
    start = 1'b0;
    tests_run++;
    if (acc_valid !== 1'b1 || acc_out !== 16'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL len_zero got valid=%b acc=%0d busy=%b exp 1 0 0",
               acc_valid, $signed(acc_out), busy);
    end
    step();
    tests_run++;
    if (acc_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL len_zero_pulse got %b exp 0", acc_valid);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] exp_acc10;
`ifdef PROD_ACCUM_SAT_EN
    exp_acc10 = 10'h1FF;
`else
    exp_acc10 = 10'h2FD;
`endif
    start = 1'b1; len = 4'd3;
    step();
    start = 1'b0; prod_valid = 1'b1; prod_in = 10'h0FF;
    step();
    step();
    tests_run++;
    if (ovf10 !== 1'b0 || acc_out10 !== 10'd510) begin
      tests_failed++;
      $display("[TB] FAIL ovf_not_yet got ovf=%b acc=%h exp 0 1fe", ovf10, acc_out10);
    end
    step();
    prod_valid = 1'b0;
    tests_run++;
    if (acc_valid10 !== 1'b1 || ovf10 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ovf_flag got valid=%b ovf=%b exp 1 1", acc_valid10, ovf10);
    end
    tests_run++;
    if (acc_out10 !== exp_acc10) begin
      tests_failed++;
      $display("[TB] FAIL ovf_value got %h exp %h", acc_out10, exp_acc10);
    end
    tests_run++;
    if (acc_out !== 16'd765 || ovf !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wide_no_ovf got acc=%0d ovf=%b exp 765 0", $signed(acc_out), ovf);
    end
    step();
    tests_run++;
    if (ovf10 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ovf_sticky got %b exp 1", ovf10);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_nominal();
    test_stalls();
    test_sign_err();
    test_len_zero();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
